// File: rtl/ecp5pll_phase_ctrl_if.sv
// rtl/ecp5pll_phase_ctrl_if.sv - phase-move request handshake between software-side master and the sequencer
interface ecp5pll_phase_ctrl_if #(
    parameter int PHASE_W = 10
);
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_ch;
    logic [PHASE_W-1:0] req_phase;

    modport master (
        output req_valid,
        output req_ch,
        output req_phase,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_ch,
        input  req_phase,
        output req_ready
    );
endinterface

// File: rtl/ecp5pll_phase_ctrl.sv
// rtl/ecp5pll_phase_ctrl.sv - ECP5 PLL dynamic phase-shift sequencer, shortest-path stepping per channel
module ecp5pll_phase_ctrl #(
    parameter int CHANNELS   = 4,
    parameter int PHASE_W    = 10,
    parameter int PHASE_MOD0 = 8,
    parameter int PHASE_MOD1 = 8,
    parameter int PHASE_MOD2 = 8,
    parameter int PHASE_MOD3 = 8,
    parameter int SETUP_CYC  = 2,
    parameter int STEP_HI    = 4,
    parameter int STEP_GAP   = 4,
    parameter int SETTLE_CYC = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_n,
    ecp5pll_phase_ctrl_if.slave    req,
    input  logic                   locked,
    output logic [1:0]             phasesel,
    output logic                   phasedir,
    output logic                   phasestep,
    output logic                   phaseloadreg,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [4*PHASE_W-1:0]   cur_phase
);

    localparam int PW1 = PHASE_W + 1;
    localparam int TW  = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WAIT_LOCK, S_SETUP, S_PULSE, S_GAP, S_SETTLE, S_DONE
    } state_t;

    state_t             state, next_state;
    logic [TW-1:0]      timer;
    logic [1:0]         lat_ch;
    logic [PHASE_W-1:0] lat_target;
    logic               dir_q;
    logic [PHASE_W-1:0] steps_q;
    logic [PHASE_W-1:0] cur_q [4];
    logic               req_ready_q;
    logic               err_c;

    logic [PW1-1:0]     mod_sel;
    logic [PHASE_W-1:0] cur_sel;
    logic [PW1-1:0]     d;
    logic               ch_ok, tgt_ok, dir_c;
    logic [PHASE_W-1:0] steps_c, next_up, next_dn;

    function automatic logic [PW1-1:0] mod_of(input logic [1:0] ch);
        case (ch)
            2'd0:    return PW1'(PHASE_MOD0);
            2'd1:    return PW1'(PHASE_MOD1);
            2'd2:    return PW1'(PHASE_MOD2);
            default: return PW1'(PHASE_MOD3);
        endcase
    endfunction

    assign req.req_ready = req_ready_q;
    assign phaseloadreg  = 1'b0;

    for (genvar n = 0; n < 4; n++) begin : g_cur
        assign cur_phase[n*PHASE_W +: PHASE_W] = cur_q[n];
    end

    // Shortest-path decision: forward distance d, go backwards only when strictly shorter.
    always_comb begin
        mod_sel = mod_of(lat_ch);
        cur_sel = cur_q[lat_ch];
        ch_ok   = int'(lat_ch) < CHANNELS;
        tgt_ok  = {1'b0, lat_target} < mod_sel;
        if (lat_target >= cur_sel)
            d = {1'b0, lat_target} - {1'b0, cur_sel};
        else
            d = {1'b0, lat_target} + mod_sel - {1'b0, cur_sel};
        dir_c   = d <= (mod_sel >> 1);
        steps_c = dir_c ? PHASE_W'(d) : PHASE_W'(mod_sel - d);
        next_up = (({1'b0, cur_sel} + PW1'(1)) == mod_sel) ? '0 : cur_sel + 1'b1;
        next_dn = (cur_sel == '0) ? PHASE_W'(mod_sel - PW1'(1)) : cur_sel - 1'b1;
    end

    always_comb begin
        next_state = state;
        err_c      = 1'b0;
        case (state)
            S_IDLE:      if (req.req_valid && req_ready_q) next_state = S_CHECK;
            S_CHECK: begin
                if (!ch_ok || !tgt_ok) begin
                    next_state = S_IDLE;
                    err_c      = 1'b1;
                end else if (d == '0) begin
                    next_state = S_DONE;
                end else begin
                    next_state = locked ? S_SETUP : S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: if (locked) next_state = S_SETUP;
            S_SETUP:     if (timer == '0) next_state = S_PULSE;
            S_PULSE:     if (timer == '0) next_state = S_GAP;
            S_GAP: begin
                if (timer == '0) begin
                    if (steps_q != '0)
                        next_state = locked ? S_SETUP : S_WAIT_LOCK;
                    else
                        next_state = (SETTLE_CYC > 0) ? S_SETTLE : S_DONE;
                end
            end
            S_SETTLE:    if (timer == '0) next_state = S_DONE;
            S_DONE:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            lat_ch      <= '0;
            lat_target  <= '0;
            dir_q       <= 1'b0;
            steps_q     <= '0;
            for (int i = 0; i < 4; i++) cur_q[i] <= '0;
            req_ready_q <= 1'b0;
            phasesel    <= '0;
            phasedir    <= 1'b0;
            phasestep   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= next_state;

            if (next_state != state) begin
                case (next_state)
                    S_SETUP:  timer <= TW'(SETUP_CYC - 1);
                    S_PULSE:  timer <= TW'(STEP_HI - 1);
                    S_GAP:    timer <= TW'(STEP_GAP - 1);
                    S_SETTLE: timer <= TW'(SETTLE_CYC - 1);
                    default:  timer <= '0;
                endcase
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end

            if (state == S_IDLE && next_state == S_CHECK) begin
                lat_ch     <= req.req_ch;
                lat_target <= req.req_phase;
            end

            if (state == S_CHECK) begin
                dir_q   <= dir_c;
                steps_q <= steps_c;
            end

            // Pins only change on the way into SETUP, so they sit still between moves.
            if (next_state == S_SETUP && state != S_SETUP) begin
                phasesel <= lat_ch;
                phasedir <= (state == S_CHECK) ? dir_c : dir_q;
            end

            if (state == S_PULSE && next_state == S_GAP) begin
                cur_q[lat_ch] <= dir_q ? next_up : next_dn;
                steps_q       <= steps_q - 1'b1;
            end

            req_ready_q <= (next_state == S_IDLE);
            busy        <= (next_state != S_IDLE) && (next_state != S_DONE);
            done        <= (next_state == S_DONE);
            err         <= err_c;
            phasestep   <= (next_state == S_PULSE);
        end
    end

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// tb/tb_ecp5pll_phase_ctrl.sv - directed self-checking bench for ecp5pll_phase_ctrl
module tb_ecp5pll_phase_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        locked;
    logic [1:0]  phasesel;
    logic        phasedir, phasestep, phaseloadreg, busy, done, err;
    logic [39:0] cur_phase;

    always #5 clk = ~clk;

    ecp5pll_phase_ctrl_if #(.PHASE_W(10)) rq ();

    ecp5pll_phase_ctrl #(
        .CHANNELS(2), .PHASE_W(10),
        .PHASE_MOD0(8), .PHASE_MOD1(16), .PHASE_MOD2(8), .PHASE_MOD3(8),
        .SETUP_CYC(2), .STEP_HI(4), .STEP_GAP(4), .SETTLE_CYC(8)
    ) dut (
        .clk_i(clk), .reset_n(reset_n), .req(rq.slave), .locked(locked),
        .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
        .phaseloadreg(phaseloadreg), .busy(busy), .done(done), .err(err),
        .cur_phase(cur_phase)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cp(input int n);
        return {22'b0, cur_phase[n*10 +: 10]};
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pulses, dir1, dir0, hi_cyc, last_start, min_per, max_per, per, sel_bad;
    logic [1:0] exp_sel;
    logic ps_prev = 1'b0;

    always @(negedge clk) begin
        if (phasestep) hi_cyc++;
        if (phasestep && !ps_prev) begin
            if (pulses > 0) begin
                per = cyc - last_start;
                if (per < min_per) min_per = per;
                if (per > max_per) max_per = per;
            end
            last_start = cyc;
            pulses++;
            if (phasedir) dir1++; else dir0++;
            if (phasesel != exp_sel) sel_bad++;
        end
        ps_prev = phasestep;
    end

    task automatic clear_mon(input logic [1:0] ch);
        pulses = 0; dir1 = 0; dir0 = 0; hi_cyc = 0; sel_bad = 0;
        min_per = 1000; max_per = 0; exp_sel = ch;
    endtask

    task automatic issue(input logic [1:0] ch, input logic [9:0] ph);
        int n;
        @(negedge clk);
        n = 0;
        while (!rq.req_ready && n < 200) begin @(negedge clk); n++; end
        if (!rq.req_ready) check("ready_wait", 0, 1);
        rq.req_valid = 1'b1; rq.req_ch = ch; rq.req_phase = ph;
        @(posedge clk);
        @(negedge clk);
        rq.req_valid = 1'b0;
        rq.req_ch    = 2'($urandom);
        rq.req_phase = 10'($urandom);
    endtask

    // lat counts clock edges from the accept edge to the edge that raised done/err.
    task automatic move(input logic [1:0] ch, input logic [9:0] ph, input bit drop_lock,
                        output int lat, output bit got_done, output bit got_err);
        int  hold;
        bit  dropped;
        clear_mon(ch);
        issue(ch, ph);
        lat = 0; got_done = 0; got_err = 0; hold = 0; dropped = 0;
        while (lat < 3000) begin
            if (done) begin got_done = 1; break; end
            if (err)  begin got_err  = 1; break; end
            if (drop_lock && !dropped && pulses == 2 && !phasestep && busy) begin
                locked  = 1'b0;
                dropped = 1;
            end else if (dropped && !locked) begin
                hold++;
                if (hold == 20) begin
                    check("lock_hold_pulses", pulses, 2);
                    check("lock_hold_busy", {31'b0, busy}, 1);
                    locked = 1'b1;
                end
            end
            @(negedge clk);
            lat++;
        end
        if (!got_done && !got_err) check("move_timeout", 0, 1);
    endtask

    task automatic after_done();
        @(negedge clk);
        check("post_done_pulse", {31'b0, done}, 0);
        check("post_done_ready", {31'b0, rq.req_ready}, 1);
        check("post_done_busy", {31'b0, busy}, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit gd, ge;
        int n;

        reset_n = 1'b0; locked = 1'b1;
        rq.req_valid = 1'b0; rq.req_ch = '0; rq.req_phase = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, rq.req_ready}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_step", {31'b0, phasestep}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_sel", {30'b0, phasesel}, 0);
        check("rst_dir", {31'b0, phasedir}, 0);
        check("rst_load", {31'b0, phaseloadreg}, 0);
        check("rst_cur", {31'b0, cur_phase == 40'd0}, 1);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", {31'b0, rq.req_ready}, 1);

        // ch1 0 -> 3: 3 forward steps, 1 (CHECK) + 3*10 + 8 settle = 39 edges.
        move(2'd1, 10'd3, 0, lat, gd, ge);
        check("m3_done", {31'b0, gd}, 1);
        check("m3_lat", lat, 39);
        check("m3_pulses", pulses, 3);
        check("m3_dir1", dir1, 3);
        check("m3_sel", sel_bad, 0);
        check("m3_per_min", min_per, 10);
        check("m3_per_max", max_per, 10);
        check("m3_hi", hi_cyc, 12);
        check("m3_cur1", cp(1), 3);
        check("m3_cur0", cp(0), 0);
        after_done();

        // ch1 3 -> 14: backward 5 steps through the wrap.
        move(2'd1, 10'd14, 0, lat, gd, ge);
        check("m14_lat", lat, 59);
        check("m14_pulses", pulses, 5);
        check("m14_dir0", dir0, 5);
        check("m14_sel", sel_bad, 0);
        check("m14_cur1", cp(1), 14);

        // ch1 14 -> 0: forward 2 through the wrap.
        move(2'd1, 10'd0, 0, lat, gd, ge);
        check("m0_lat", lat, 29);
        check("m0_dir1", dir1, 2);
        check("m0_cur1", cp(1), 0);

        // Tie at MOD/2 goes forward.
        move(2'd1, 10'd8, 0, lat, gd, ge);
        check("tie_lat", lat, 89);
        check("tie_pulses", pulses, 8);
        check("tie_dir1", dir1, 8);
        check("tie_cur1", cp(1), 8);

        // Same target again: done straight out of CHECK.
        move(2'd1, 10'd8, 0, lat, gd, ge);
        check("zero_done", {31'b0, gd}, 1);
        check("zero_lat", lat, 1);
        check("zero_pulses", pulses, 0);
        after_done();

        // Out-of-range target and channel.
        move(2'd0, 10'd8, 0, lat, gd, ge);
        check("bad_tgt_err", {31'b0, ge}, 1);
        check("bad_tgt_lat", lat, 1);
        check("bad_tgt_pulses", pulses, 0);
        check("bad_tgt_cur0", cp(0), 0);
        check("bad_tgt_cur1", cp(1), 8);
        @(negedge clk);
        check("bad_tgt_err_1cyc", {31'b0, err}, 0);
        move(2'd3, 10'd0, 0, lat, gd, ge);
        check("bad_ch_err", {31'b0, ge}, 1);
        check("bad_ch_done", {31'b0, gd}, 0);

        // ch0 MOD 8: 0 -> 7 is one backward step.
        move(2'd0, 10'd7, 0, lat, gd, ge);
        check("m7_lat", lat, 19);
        check("m7_dir0", dir0, 1);
        check("m7_sel", sel_bad, 0);
        check("m7_cur0", cp(0), 7);
        check("m7_cur1", cp(1), 8);

        // Lock loss in second GAP holds pulse 3 until relock.
        move(2'd1, 10'd12, 1, lat, gd, ge);
        check("lock_done", {31'b0, gd}, 1);
        check("lock_pulses", pulses, 4);
        check("lock_dir1", dir1, 4);
        check("lock_lat_ext", {31'b0, lat > 49}, 1);
        check("lock_cur1", cp(1), 12);

        // Reset in the middle of pulse 2 of an 8-step move.
        clear_mon(2'd1);
        issue(2'd1, 10'd4);
        n = 0;
        while (!(pulses == 2 && phasestep) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) check("rst_mid_wait", 0, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_step", {31'b0, phasestep}, 0);
        check("rst_mid_busy", {31'b0, busy}, 0);
        check("rst_mid_cur", {31'b0, cur_phase == 40'd0}, 1);
        check("rst_mid_ready", {31'b0, rq.req_ready}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mid_ready_rel", {31'b0, rq.req_ready}, 1);

        move(2'd1, 10'd1, 0, lat, gd, ge);
        check("post_rst_lat", lat, 19);
        check("post_rst_dir1", dir1, 1);
        check("post_rst_cur1", cp(1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
